// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding and one-hot helper for the decoder blocks (select width up to MAX_N)
package decoder_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;
  localparam int MAX_N = 8;
  function automatic logic [2**MAX_N-1:0] onehot(input logic [MAX_N-1:0] s);
    return {{(2**MAX_N-1){1'b0}}, 1'b1} << s;
  endfunction
endpackage

// File: rtl/decoder_n.sv
// decoder_n: combinational N-to-2^N binary decoder; sel in, one-hot y out
module decoder_n
  import decoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel,
  input  logic [2**N-1:0] unused_tie,
  output logic [2**N-1:0] y
);
  localparam int W = 2**N;
  assign y = W'(onehot(MAX_N'(sel))) | (unused_tie & '0);
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with handshaked decode mode and rotating scan mode; ports clk, reset_n, en, mode, sel/sel_valid/sel_ready, dwell, y, idx, wrap
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    y,
  output logic [N-1:0]       idx,
  output logic               wrap
);
  localparam int W = 2**N;
  state_t state, state_nx;
  logic [DWELL_W-1:0] cnt;
  logic [W-1:0] dec;
  decoder_n #(.N(N)) u_dec (.sel(sel), .unused_tie('0), .y(dec));
  always_comb begin
    state_nx  = !en ? IDLE : mode ? SCAN : DECODE;
    sel_ready = en && !mode && state == DECODE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      y     <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      wrap  <= 1'b0;
      if (!en) begin
        y <= '0;
      end else if (mode) begin
        // every entry into scan, from idle or decode, restarts at position 0
        if (state != SCAN) begin
          y   <= W'(1);
          idx <= '0;
          cnt <= dwell;
        end else if (cnt == '0) begin
          y    <= {y[W-2:0], y[W-1]};
          idx  <= idx + N'(1);
          cnt  <= dwell;
          wrap <= &idx;
        end else begin
          cnt <= cnt - DWELL_W'(1);
        end
      end else if (sel_valid && sel_ready) begin
        y   <= dec;
        idx <= sel;
      end
    end
  end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: table vectors, hand sequences and a randomized reference model for decoder_scan
module tb_decoder_scan;
  logic clk = 0, reset_n = 0;
  logic en = 0, mode = 0, sel_valid = 0, sel_ready;
  logic [2:0] sel = 0, idx;
  logic [7:0] dwell = 0, y;
  logic wrap;
  logic en4 = 0, mode4 = 0, sel_valid4 = 0, sel_ready4, wrap4;
  logic [3:0] sel4 = 0, idx4;
  logic [7:0] dwell4 = 0;
  logic [15:0] y4;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  decoder_scan #(.N(3), .DWELL_W(8)) dut3 (.clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .sel(sel), .sel_valid(sel_valid), .sel_ready(sel_ready), .dwell(dwell), .y(y), .idx(idx), .wrap(wrap));
  decoder_scan #(.N(4), .DWELL_W(8)) dut4 (.clk(clk), .reset_n(reset_n), .en(en4), .mode(mode4),
    .sel(sel4), .sel_valid(sel_valid4), .sel_ready(sel_ready4), .dwell(dwell4), .y(y4), .idx(idx4), .wrap(wrap4));

  // behavioural reference for the N=3 instance: scan position from elapsed cycles since entry
  logic [7:0] m_y;
  logic [2:0] m_idx;
  logic m_wrap;
  int m_phase, m_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y = 0; m_idx = 0; m_wrap = 0; m_phase = 0; m_t = 0;
  endtask

  task automatic model_step();
    int pos;
    m_wrap = 0;
    if (!en) m_y = 0;
    else if (mode) begin
      m_t = (m_phase == 2) ? m_t + 1 : 0;
      pos = (m_t / (int'(dwell) + 1)) % 8;
      m_wrap = m_t > 0 && m_t % (int'(dwell) + 1) == 0 && pos == 0;
      m_y = 8'(1) << pos;
      m_idx = 3'(pos);
    end else if (m_phase == 1 && sel_valid) begin
      m_y = 8'(1) << sel;
      m_idx = sel;
    end
    m_phase = !en ? 0 : mode ? 2 : 1;
  endtask

  task automatic cyc();
    #1 chk("sel_ready", sel_ready, en && !mode && m_phase == 1);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("y", y, m_y);
    chk("idx", idx, m_idx);
    chk("wrap", wrap, m_wrap);
  endtask

  typedef struct {logic [2:0] sel; logic [7:0] exp_y;} vec_t;
  vec_t vt[8];
  int first_wrap, wraps;

  initial begin
    vt[0] = '{3'd0, 8'h01}; vt[1] = '{3'd1, 8'h02}; vt[2] = '{3'd2, 8'h04}; vt[3] = '{3'd3, 8'h08};
    vt[4] = '{3'd4, 8'h10}; vt[5] = '{3'd5, 8'h20}; vt[6] = '{3'd6, 8'h40}; vt[7] = '{3'd7, 8'h80};
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_y", y, 8'h00);
    chk("reset_ready", sel_ready, 1'b0);
    reset_n = 1;
    cyc(); cyc();
    chk("idle_y", y, 8'h00);

    // decode sweep from the table
    en = 1; mode = 0; cyc();
    for (int i = 0; i < 8; i++) begin
      sel = vt[i].sel; sel_valid = 1;
      #1 chk("sweep_ready", sel_ready, 1'b1);
      cyc();
      chk("sweep_y", y, vt[i].exp_y);
    end
    sel_valid = 0;

    // scan with dwell=2: wrap 24 cycles after first 8'h01, sel_valid ignored
    dwell = 2; mode = 1; cyc();
    chk("scan_first", y, 8'h01);
    first_wrap = -1; wraps = 0;
    for (int k = 1; k <= 30; k++) begin
      sel_valid = 1'($urandom_range(0, 1)); sel = 3'($urandom);
      cyc();
      if (k < 3) chk("scan_hold", y, 8'h01);
      if (k == 3) chk("scan_second", y, 8'h02);
      if (wrap) begin wraps++; if (first_wrap < 0) first_wrap = k; end
    end
    chk("wrap_dist", first_wrap, 24);
    chk("wrap_count", wraps, 1);
    sel_valid = 0;

    // mode switch at idx=5 with dwell=0
    mode = 0; cyc(); dwell = 0; mode = 1;
    for (int k = 0; k < 6; k++) cyc();
    chk("sw_scan5", y, 8'h20);
    mode = 0; cyc();
    chk("sw_hold", y, 8'h20);
    cyc();
    chk("sw_hold2", y, 8'h20);
    sel = 2; sel_valid = 1; cyc();
    chk("sw_dec", y, 8'h04);
    sel_valid = 0; mode = 1; cyc();
    chk("sw_restart", y, 8'h01);

    // enable drop and re-enable with dwell reload
    cyc(); cyc();
    en = 0; cyc();
    chk("en_drop", y, 8'h00);
    dwell = 2; en = 1; cyc();
    cyc(); cyc();
    chk("reen_hold", y, 8'h01);
    cyc();
    chk("reen_adv", y, 8'h02);

    // asynchronous reset mid-scan
    cyc(); cyc(); cyc();
    #2 reset_n = 0;
    #1 chk("areset_y", y, 8'h00);
    chk("areset_idx", idx, 3'd0);
    chk("areset_wrap", wrap, 1'b0);
    model_reset();
    @(negedge clk); reset_n = 1; en = 0;
    cyc(); cyc();
    chk("post_reset_y", y, 8'h00);

    // N=4, dwell=0: advance every cycle, wrap every 16
    en4 = 1; mode4 = 1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      chk("n4_y", y4, 16'(1) << (k % 16));
      chk("n4_wrap", wrap4, k > 0 && k % 16 == 0);
      @(negedge clk);
    end
    en4 = 0;

    // randomized runs against the model, dwell fixed per run
    for (int r = 0; r < 3; r++) begin
      reset_n = 0; #1; model_reset();
      @(negedge clk); reset_n = 1;
      dwell = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : 8'd3;
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(0, 15) == 0) en = ~en;
        if ($urandom_range(0, 19) == 0) mode = ~mode;
        sel = 3'($urandom); sel_valid = 1'($urandom);
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
